// File: rtl/bbqm_queue_ctrl.sv
// Queue controller: synchronised arrive/depart events, occupancy status, and
// estimated wait time ceil(count*SVC_TIME/tellers) in binary and BCD.
module bbqm_queue_ctrl #(
    parameter int unsigned MAX_Q    = 15,
    parameter int unsigned SVC_TIME = 3,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned TELLER_W = 2,
    parameter int unsigned WT_W     = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arrive,
    input  logic                depart,
    input  logic [TELLER_W-1:0] tellers,
    output logic [CNT_W-1:0]    count,
    output logic                empty,
    output logic                full,
    output logic                overflow,
    output logic                underflow,
    output logic                closed,
    output logic [WT_W-1:0]     wt_bin,
    output logic [7:0]          wt_bcd,
    output logic                wt_valid
);

    localparam int unsigned NW     = WT_W + TELLER_W;
    localparam int unsigned TW1    = TELLER_W + 1;
    localparam int unsigned DW     = WT_W + 8;
    localparam int unsigned STEP_W = $clog2(WT_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WT_W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, BCD, DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]          a_sync, d_sync;
    logic                a_evt, d_evt;
    logic [CNT_W-1:0]    cnt_nxt_c;
    logic                ovf_c, unf_c;

    logic [CNT_W-1:0]    lat_cnt;
    logic [TELLER_W-1:0] lat_tel;
    logic                force_q;
    logic                changed_c;
    logic [TELLER_W-1:0] rem;
    logic [WT_W-1:0]     dq;
    logic [WT_W-1:0]     bin_sr;
    logic [7:0]          bcd_sr;
    logic [STEP_W-1:0]   step;

    logic [NW-1:0]       num_c;
    logic [TW1-1:0]      trial_c, diff_c;
    logic                sub_ok_c;
    logic [WT_W-1:0]     dq_nxt_c;
    logic [7:0]          bcd_adj_c;
    logic [DW-1:0]       dd_c;

    // Two-flop synchroniser, third flop for edge detect, registered event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync <= '0;
            d_sync <= '0;
            a_evt  <= 1'b0;
            d_evt  <= 1'b0;
        end else begin
            a_sync <= {a_sync[1:0], arrive};
            d_sync <= {d_sync[1:0], depart};
            a_evt  <= a_sync[1] & ~a_sync[2];
            d_evt  <= d_sync[1] & ~d_sync[2];
        end
    end

    // Simultaneous arrive+depart on an empty queue admits the arrival.
    always_comb begin
        cnt_nxt_c = count;
        ovf_c     = 1'b0;
        unf_c     = 1'b0;
        if (a_evt && !d_evt) begin
            if (count < CNT_W'(MAX_Q)) cnt_nxt_c = count + CNT_W'(1);
            else                       ovf_c     = 1'b1;
        end else if (!a_evt && d_evt) begin
            if (count != '0) cnt_nxt_c = count - CNT_W'(1);
            else             unf_c     = 1'b1;
        end else if (a_evt && d_evt && count == '0) begin
            cnt_nxt_c = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= cnt_nxt_c;
            empty     <= (cnt_nxt_c == '0);
            full      <= (cnt_nxt_c == CNT_W'(MAX_Q));
            overflow  <= ovf_c;
            underflow <= unf_c;
        end
    end

    // Wait-time datapath: numerator, restoring-divide step, double-dabble step.
    always_comb begin
        changed_c = force_q || (count != lat_cnt) || (tellers != lat_tel);
        num_c     = NW'(count) * NW'(SVC_TIME) + NW'(tellers) - NW'(1);
        trial_c   = {rem, dq[WT_W-1]};
        sub_ok_c  = (trial_c >= TW1'(lat_tel));
        diff_c    = trial_c - TW1'(lat_tel);
        dq_nxt_c  = {dq[WT_W-2:0], sub_ok_c};
        bcd_adj_c[3:0] = (bcd_sr[3:0] >= 4'd5) ? bcd_sr[3:0] + 4'd3 : bcd_sr[3:0];
        bcd_adj_c[7:4] = (bcd_sr[7:4] >= 4'd5) ? bcd_sr[7:4] + 4'd3 : bcd_sr[7:4];
        dd_c      = {bcd_adj_c, bin_sr} << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (changed_c) state_nxt = LOAD;
            LOAD: state_nxt = (tellers == '0) ? DONE : DIV;
            DIV: begin
                if (changed_c)              state_nxt = LOAD;
                else if (step == LAST_STEP) state_nxt = BCD;
            end
            BCD: begin
                if (changed_c)              state_nxt = LOAD;
                else if (step == LAST_STEP) state_nxt = DONE;
            end
            DONE:    state_nxt = changed_c ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are published only in DONE, so they hold until a computation completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt  <= '0;
            lat_tel  <= '0;
            force_q  <= 1'b1;
            rem      <= '0;
            dq       <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            step     <= '0;
            closed   <= 1'b0;
            wt_bin   <= '0;
            wt_bcd   <= 8'h00;
            wt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (changed_c) wt_valid <= 1'b0;
                LOAD: begin
                    lat_cnt  <= count;
                    lat_tel  <= tellers;
                    force_q  <= 1'b0;
                    wt_valid <= 1'b0;
                    step     <= '0;
                    if (tellers == '0) begin
                        closed <= 1'b1;
                        wt_bin <= '0;
                        wt_bcd <= 8'h00;
                    end else begin
                        closed <= 1'b0;
                        rem    <= num_c[NW-1:WT_W];
                        dq     <= num_c[WT_W-1:0];
                    end
                end
                DIV: begin
                    rem <= sub_ok_c ? TELLER_W'(diff_c) : TELLER_W'(trial_c);
                    dq  <= dq_nxt_c;
                    if (step == LAST_STEP) begin
                        step   <= '0;
                        bin_sr <= dq_nxt_c;
                        bcd_sr <= 8'h00;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                BCD: begin
                    bcd_sr <= dd_c[DW-1:WT_W];
                    bin_sr <= dd_c[WT_W-1:0];
                    step   <= step + STEP_W'(1);
                end
                DONE: begin
                    if (!changed_c) begin
                        wt_valid <= 1'b1;
                        if (!closed) begin
                            wt_bin <= dq;
                            wt_bcd <= bcd_sr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bbqm_queue_ctrl.sv
// Bench for bbqm_queue_ctrl: cycle-level occupancy model plus wait-time
// property checks, directed scenarios and randomized button traffic.
module tb_bbqm_queue_ctrl;

    localparam int MAX_Q = 15;
    localparam int SVC   = 3;
    localparam int WT_W  = 6;
    localparam int LAT   = 2 * WT_W + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arrive = 1'b0;
    logic       depart = 1'b0;
    logic [1:0] tellers = 2'd1;
    logic [3:0] count;
    logic       empty, full, overflow, underflow, closed, wt_valid;
    logic [5:0] wt_bin;
    logic [7:0] wt_bcd;

    int cmp_n = 0;
    int err_n = 0;
    int ov_seen = 0;
    int uf_seen = 0;

    // Model state
    logic [4:0] ha = '0, hd = '0;
    int  m_cnt = 0, m_ov = 0, m_uf = 0;
    int  stable = 0, p_cnt = 0, p_tel = 0, c_tel = 0, lat = LAT;
    int  e_bin, e_bcd, e_cl;
    bit  ea, ed;

    bbqm_queue_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .arrive   (arrive),
        .depart   (depart),
        .tellers  (tellers),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow),
        .closed   (closed),
        .wt_bin   (wt_bin),
        .wt_bcd   (wt_bcd),
        .wt_valid (wt_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic void calc_wait(input int c, input int t, output int b, output int bcd, output int cl);
        int tot;
        if (t == 0) begin
            b = 0; bcd = 0; cl = 1;
        end else begin
            tot = c * SVC;
            b = tot / t;
            if (b * t < tot) b++;
            bcd = (b / 10) * 16 + (b % 10);
            cl = 0;
        end
    endfunction

    // Compare process: occupancy is modelled exactly; wait time is checked as
    // "valid implies correct for the previous cycle's inputs" plus latency bounds.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                ha = '0; hd = '0;
                m_cnt = 0; m_ov = 0; m_uf = 0;
                stable = 0; p_cnt = 0; p_tel = int'(tellers);
                #1;
                check("rst_count", count, 0);
                check("rst_empty", empty, 1);
                check("rst_valid", wt_valid, 0);
            end else begin
                ha = {ha[3:0], arrive};
                hd = {hd[3:0], depart};
                ea = ha[3] && !ha[4];
                ed = hd[3] && !hd[4];
                m_ov = 0; m_uf = 0;
                if (ea && !ed) begin
                    if (m_cnt < MAX_Q) m_cnt++; else m_ov = 1;
                end else if (!ea && ed) begin
                    if (m_cnt > 0) m_cnt--; else m_uf = 1;
                end else if (ea && ed && m_cnt == 0) begin
                    m_cnt = 1;
                end
                c_tel = int'(tellers);
                if (m_cnt != p_cnt || c_tel != p_tel) stable = 0;
                else if (stable < 100000) stable++;
                lat = (c_tel == 0) ? 3 : LAT;
                #1;
                check("count", count, m_cnt);
                check("empty", empty, (m_cnt == 0));
                check("full", full, (m_cnt == MAX_Q));
                check("overflow", overflow, m_ov);
                check("underflow", underflow, m_uf);
                if (overflow)  ov_seen++;
                if (underflow) uf_seen++;
                if (stable >= lat)
                    check("wt_valid_due", wt_valid, 1);
                else if (stable >= 1 && stable <= lat - 3)
                    check("wt_valid_early", wt_valid, 0);
                if (wt_valid) begin
                    calc_wait(p_cnt, p_tel, e_bin, e_bcd, e_cl);
                    check("wt_bin", wt_bin, e_bin);
                    check("wt_bcd", wt_bcd, e_bcd);
                    check("closed", closed, e_cl);
                end
                p_cnt = m_cnt;
                p_tel = c_tel;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; arrive = 1'b0; depart = 1'b0;
        #1;
        check("reset_count", count, 0);
        check("reset_empty", empty, 1);
        check("reset_full", full, 0);
        check("reset_valid", wt_valid, 0);
        check("reset_bcd", wt_bcd, 8'h00);
        check("reset_closed", closed, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic a, input logic d);
        @(negedge clk);
        arrive = a; depart = d;
        repeat (3) @(negedge clk);
        arrive = 1'b0; depart = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Last arrival with exact wait-time latency measured from the count change.
    task automatic timed_arrival(input int target, input int e_b, input int e_bc);
        bit found;
        @(negedge clk); arrive = 1'b1;
        @(negedge clk);
        @(negedge clk); arrive = 1'b0;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk); #2;
            if (count == 4'(target)) found = 1;
        end
        check("timed_count", count, target);
        repeat (14) @(posedge clk); #2;
        check("timed_valid_at_14", wt_valid, 0);
        @(posedge clk); #2;
        check("timed_valid_at_15", wt_valid, 1);
        check("timed_bin", wt_bin, e_b);
        check("timed_bcd", wt_bcd, e_bc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset then idle with one teller
        tellers = 2'd1;
        do_reset();
        repeat (14) @(posedge clk); #2;
        check("idle_valid_14", wt_valid, 0);
        @(posedge clk); #2;
        check("idle_valid_15", wt_valid, 1);
        check("idle_bin", wt_bin, 0);
        check("idle_bcd", wt_bcd, 8'h00);

        // Five arrivals, two tellers: ceil(15/2) = 8
        tellers = 2'd2;
        do_reset();
        repeat (4) pulse(1'b1, 1'b0);
        timed_arrival(5, 8, 8'h08);

        // Saturation at MAX_Q with three tellers
        tellers = 2'd3;
        do_reset();
        ov_seen = 0; uf_seen = 0;
        repeat (16) pulse(1'b1, 1'b0);
        repeat (LAT + 5) @(posedge clk); #2;
        check("sat_count", count, 15);
        check("sat_full", full, 1);
        check("sat_ovf_pulses", ov_seen, 1);
        check("sat_valid", wt_valid, 1);
        check("sat_bin", wt_bin, 15);
        check("sat_bcd", wt_bcd, 8'h15);

        // Underflow and simultaneous events at both ends
        tellers = 2'd1;
        do_reset();
        ov_seen = 0; uf_seen = 0;
        pulse(1'b0, 1'b1);
        check("uf_pulses", uf_seen, 1);
        check("uf_count", count, 0);
        ov_seen = 0; uf_seen = 0;
        pulse(1'b1, 1'b1);
        check("both_at0_count", count, 1);
        check("both_at0_pulses", ov_seen + uf_seen, 0);
        repeat (14) pulse(1'b1, 1'b0);
        ov_seen = 0; uf_seen = 0;
        pulse(1'b1, 1'b1);
        check("both_atmax_count", count, 15);
        check("both_atmax_pulses", ov_seen + uf_seen, 0);

        // Closed path, then reopen with one teller
        tellers = 2'd1;
        do_reset();
        repeat (4) pulse(1'b1, 1'b0);
        repeat (LAT + 5) @(posedge clk);
        @(negedge clk); tellers = 2'd0;
        repeat (3) @(posedge clk); #2;
        check("closed_flag", closed, 1);
        check("closed_valid", wt_valid, 1);
        check("closed_bcd", wt_bcd, 8'h00);
        check("closed_bin", wt_bin, 0);
        @(negedge clk); tellers = 2'd1;
        repeat (14) @(posedge clk); #2;
        check("reopen_valid_14", wt_valid, 0);
        @(posedge clk); #2;
        check("reopen_valid_15", wt_valid, 1);
        check("reopen_bin", wt_bin, 12);
        check("reopen_bcd", wt_bcd, 8'h12);
        check("reopen_closed", closed, 0);

        // Teller change during the fourth divide cycle restarts the computation
        @(negedge clk); tellers = 2'd2;
        repeat (5) @(posedge clk);
        @(negedge clk); tellers = 2'd3;
        repeat (14) @(posedge clk); #2;
        check("abort_valid_14", wt_valid, 0);
        @(posedge clk); #2;
        check("abort_valid_15", wt_valid, 1);
        check("abort_bin", wt_bin, 4);
        check("abort_bcd", wt_bcd, 8'h04);

        // Reset in the middle of the BCD phase
        @(negedge clk); tellers = 2'd1;
        repeat (10) @(posedge clk);
        #3;
        check("pre_rst_count", count, 4);
        reset = 1'b1;
        #1;
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        check("midrst_ovf", overflow, 0);
        check("midrst_unf", underflow, 0);
        check("midrst_closed", closed, 0);
        check("midrst_bin", wt_bin, 0);
        check("midrst_bcd", wt_bcd, 8'h00);
        check("midrst_valid", wt_valid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Randomized traffic: arrival-heavy first, departure-heavy second
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            arrive = ($urandom_range(0, 9) < ((i < 200) ? 7 : 3));
            depart = ($urandom_range(0, 9) < ((i < 200) ? 3 : 7));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 24) == 0) begin
                tellers = 2'($urandom_range(0, 3));
                arrive = 1'b0; depart = 1'b0;
                repeat (LAT + 3) @(negedge clk);
            end
        end
        arrive = 1'b0; depart = 1'b0;
        repeat (LAT + 5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
